// File: rtl/priority_queue_sorted.sv
// Sorted priority queue built as an insertion-sort shift array.
// Push and pop can both be accepted in one cycle; the head entry is always registered on the outputs.
module priority_queue_sorted #(
  parameter int DATA_LENGTH = 32,
  parameter int TAG_LENGTH  = 8,
  parameter int DEPTH       = 16,
  parameter int MAX_FIRST   = 1,
  parameter int CNT_W       = $clog2(DEPTH+1)
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [DATA_LENGTH-1:0] i_key,
  input  logic [TAG_LENGTH-1:0]  i_tag,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_valid,
  output logic [DATA_LENGTH-1:0] o_key,
  output logic [TAG_LENGTH-1:0]  o_tag,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  logic [DATA_LENGTH-1:0] key_q [DEPTH];
  logic [DATA_LENGTH-1:0] key_d [DEPTH];
  logic [TAG_LENGTH-1:0]  tag_q [DEPTH];
  logic [TAG_LENGTH-1:0]  tag_d [DEPTH];
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic [DATA_LENGTH-1:0] sh_key [DEPTH];
  logic [TAG_LENGTH-1:0]  sh_tag [DEPTH];
  logic [DEPTH-1:0]       sh_vld;
  logic [CNT_W-1:0]       ins_p;
  logic                   do_pop, do_push;

  // Ties count as "better-or-equal" so a new key lands behind equal keys (stable order).
  function automatic logic better_eq(input logic [DATA_LENGTH-1:0] a,
                                     input logic [DATA_LENGTH-1:0] b);
    if (MAX_FIRST != 0) return (a >= b);
    else                return (a <= b);
  endfunction

  always_comb begin
    do_pop  = i_pop && (count_q != '0);
    do_push = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Array as it looks after an optional head removal; insertion is computed against this.
    for (int i = 0; i < DEPTH-1; i++) begin
      sh_key[i] = do_pop ? key_q[i+1] : key_q[i];
      sh_tag[i] = do_pop ? tag_q[i+1] : tag_q[i];
      sh_vld[i] = do_pop ? vld_q[i+1] : vld_q[i];
    end
    sh_key[DEPTH-1] = do_pop ? '0   : key_q[DEPTH-1];
    sh_tag[DEPTH-1] = do_pop ? '0   : tag_q[DEPTH-1];
    sh_vld[DEPTH-1] = do_pop ? 1'b0 : vld_q[DEPTH-1];

    ins_p = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sh_vld[i] && better_eq(sh_key[i], i_key)) ins_p = ins_p + CNT_W'(1);
    end

    for (int i = 0; i < DEPTH; i++) begin
      key_d[i] = sh_key[i];
      tag_d[i] = sh_tag[i];
      vld_d[i] = sh_vld[i];
    end
    if (do_push && (ins_p == '0)) begin
      key_d[0] = i_key;
      tag_d[0] = i_tag;
      vld_d[0] = 1'b1;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (do_push) begin
        if (ins_p == CNT_W'(i)) begin
          key_d[i] = i_key;
          tag_d[i] = i_tag;
          vld_d[i] = 1'b1;
        end else if (ins_p < CNT_W'(i)) begin
          key_d[i] = sh_key[i-1];
          tag_d[i] = sh_tag[i-1];
          vld_d[i] = sh_vld[i-1];
        end
      end
    end

    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);

    ovf_d = i_push && !do_push && !i_flush;
    unf_d = i_pop  && !do_pop  && !i_flush;

    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_d[i] = '0;
        tag_d[i] = '0;
      end
      vld_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        tag_q[i] <= '0;
      end
      vld_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= key_d[i];
        tag_q[i] <= tag_d[i];
      end
      vld_q   <= vld_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_key       = key_q[0];
  assign o_tag       = tag_q[0];
  assign o_valid     = vld_q[0];
  assign o_count     = count_q;
  assign o_empty     = (count_q == '0);
  assign o_full      = (count_q == CNT_W'(DEPTH));
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_priority_queue_sorted.sv
// Scoreboard bench: two DEPTH=4 queues (max-first and min-first) share stimulus;
// each step queues the hand-computed head state for one of them, checked by a separate monitor.
module tb_priority_queue_sorted;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        i_flush, i_push, i_pop;
  logic [31:0] i_key;
  logic [7:0]  i_tag;

  logic        o0_full, o0_empty, o0_valid, o0_ovf, o0_unf;
  logic [31:0] o0_key;
  logic [7:0]  o0_tag;
  logic [2:0]  o0_count;
  logic        o1_full, o1_empty, o1_valid, o1_ovf, o1_unf;
  logic [31:0] o1_key;
  logic [7:0]  o1_tag;
  logic [2:0]  o1_count;

  int checks   = 0;
  int failures = 0;
  int step_id  = 0;

  typedef struct {
    int id;
    bit sel;
    int cnt;
    int key;
    int tag;
    bit ovf;
    bit unf;
  } exp_t;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  priority_queue_sorted #(.DATA_LENGTH(32), .TAG_LENGTH(8), .DEPTH(4), .MAX_FIRST(1)) u_max (
    .CLK(CLK), .RSTn(RSTn), .i_flush(i_flush), .i_push(i_push), .i_key(i_key), .i_tag(i_tag),
    .i_pop(i_pop), .o_full(o0_full), .o_empty(o0_empty), .o_valid(o0_valid), .o_key(o0_key),
    .o_tag(o0_tag), .o_count(o0_count), .o_overflow(o0_ovf), .o_underflow(o0_unf));

  priority_queue_sorted #(.DATA_LENGTH(32), .TAG_LENGTH(8), .DEPTH(4), .MAX_FIRST(0)) u_min (
    .CLK(CLK), .RSTn(RSTn), .i_flush(i_flush), .i_push(i_push), .i_key(i_key), .i_tag(i_tag),
    .i_pop(i_pop), .o_full(o1_full), .o_empty(o1_empty), .o_valid(o1_valid), .o_key(o1_key),
    .o_tag(o1_tag), .o_count(o1_count), .o_overflow(o1_ovf), .o_underflow(o1_unf));

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic step(input bit push, input int key, input int tag, input bit pop, input bit flush,
                      input bit sel, input int cnt, input int ekey, input int etag,
                      input bit ovf, input bit unf);
    exp_t e;
    @(negedge CLK);
    i_push = push; i_key = key; i_tag = tag[7:0]; i_pop = pop; i_flush = flush;
    step_id++;
    e.id = step_id; e.sel = sel; e.cnt = cnt; e.key = ekey; e.tag = etag; e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge CLK);
    i_push = 0; i_pop = 0; i_flush = 0; i_key = 0; i_tag = 0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_count"}, int'(o0_count), 0);
    chk({nm, "_valid"}, int'(o0_valid), 0);
    chk({nm, "_empty"}, int'(o0_empty), 1);
    chk({nm, "_full"},  int'(o0_full),  0);
    chk({nm, "_key"},   int'(o0_key),   0);
    chk({nm, "_tag"},   int'(o0_tag),   0);
    chk({nm, "_ovf"},   int'(o0_ovf),   0);
    chk({nm, "_unf"},   int'(o0_unf),   0);
  endtask

  // Monitor: the DUT presents new head state after every edge; compare against the next queued entry.
  always @(posedge CLK) begin
    exp_t e;
    string s;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = $sformatf("step%0d_dut%0d", e.id, e.sel);
      chk({s, "_count"}, int'(e.sel ? o1_count : o0_count), e.cnt);
      chk({s, "_valid"}, int'(e.sel ? o1_valid : o0_valid), (e.cnt != 0) ? 1 : 0);
      chk({s, "_empty"}, int'(e.sel ? o1_empty : o0_empty), (e.cnt == 0) ? 1 : 0);
      chk({s, "_full"},  int'(e.sel ? o1_full  : o0_full),  (e.cnt == 4) ? 1 : 0);
      chk({s, "_key"},   int'(e.sel ? o1_key   : o0_key),   e.key);
      chk({s, "_tag"},   int'(e.sel ? o1_tag   : o0_tag),   e.tag);
      chk({s, "_ovf"},   int'(e.sel ? o1_ovf   : o0_ovf),   int'(e.ovf));
      chk({s, "_unf"},   int'(e.sel ? o1_unf   : o0_unf),   int'(e.unf));
    end
  end

  initial begin
    RSTn = 0; i_push = 0; i_pop = 0; i_flush = 0; i_key = 0; i_tag = 0;
    #12;
    chk_reset_outputs("reset");
    @(negedge CLK);
    RSTn = 1;

    //   push key tag  pop flush sel cnt key tag ovf unf
    step(0, 0,  0,    0, 0,    0,  0,  0,  0,   0,  0);
    // max-first ordering
    step(1, 5,  'hA,  0, 0,    0,  1,  5,  'hA, 0,  0);
    step(1, 9,  'hB,  0, 0,    0,  2,  9,  'hB, 0,  0);
    step(1, 1,  'hC,  0, 0,    0,  3,  9,  'hB, 0,  0);
    step(1, 7,  'hD,  0, 0,    0,  4,  9,  'hB, 0,  0);
    step(0, 0,  0,    1, 0,    0,  3,  7,  'hD, 0,  0);
    step(0, 0,  0,    1, 0,    0,  2,  5,  'hA, 0,  0);
    step(0, 0,  0,    1, 0,    0,  1,  1,  'hC, 0,  0);
    step(0, 0,  0,    1, 0,    0,  0,  0,  0,   0,  0);
    // min-first ordering and underflow
    step(1, 30, 1,    0, 0,    1,  1,  30, 1,   0,  0);
    step(1, 10, 2,    0, 0,    1,  2,  10, 2,   0,  0);
    step(1, 20, 3,    0, 0,    1,  3,  10, 2,   0,  0);
    step(0, 0,  0,    1, 0,    1,  2,  20, 3,   0,  0);
    step(0, 0,  0,    1, 0,    1,  1,  30, 1,   0,  0);
    step(0, 0,  0,    1, 0,    1,  0,  0,  0,   0,  0);
    step(0, 0,  0,    1, 0,    1,  0,  0,  0,   0,  1);
    step(0, 0,  0,    0, 0,    1,  0,  0,  0,   0,  0);
    // stability of equal keys
    step(1, 4,  1,    0, 0,    0,  1,  4,  1,   0,  0);
    step(1, 4,  2,    0, 0,    0,  2,  4,  1,   0,  0);
    step(1, 4,  3,    0, 0,    0,  3,  4,  1,   0,  0);
    step(0, 0,  0,    1, 0,    0,  2,  4,  2,   0,  0);
    step(0, 0,  0,    1, 0,    0,  1,  4,  3,   0,  0);
    step(0, 0,  0,    1, 0,    0,  0,  0,  0,   0,  0);
    // fill, overflow, push+pop while full
    step(1, 8,  1,    0, 0,    0,  1,  8,  1,   0,  0);
    step(1, 6,  2,    0, 0,    0,  2,  8,  1,   0,  0);
    step(1, 4,  3,    0, 0,    0,  3,  8,  1,   0,  0);
    step(1, 2,  4,    0, 0,    0,  4,  8,  1,   0,  0);
    step(1, 5,  5,    0, 0,    0,  4,  8,  1,   1,  0);
    step(0, 0,  0,    0, 0,    0,  4,  8,  1,   0,  0);
    step(1, 5,  5,    1, 0,    0,  4,  6,  2,   0,  0);
    step(0, 0,  0,    1, 0,    0,  3,  5,  5,   0,  0);
    step(0, 0,  0,    1, 0,    0,  2,  4,  3,   0,  0);
    step(0, 0,  0,    1, 0,    0,  1,  2,  4,   0,  0);
    step(0, 0,  0,    1, 0,    0,  0,  0,  0,   0,  0);
    step(0, 0,  0,    0, 1,    0,  0,  0,  0,   0,  0);
    // push+pop on empty, then flush beats push
    step(1, 3,  7,    1, 0,    0,  1,  3,  7,   0,  1);
    step(1, 9,  9,    0, 1,    0,  0,  0,  0,   0,  0);
    step(0, 0,  0,    0, 0,    1,  0,  0,  0,   0,  0);
    // async reset mid-stream
    step(1, 1,  1,    0, 0,    0,  1,  1,  1,   0,  0);
    step(1, 2,  2,    0, 0,    0,  2,  2,  2,   0,  0);
    step(1, 3,  3,    0, 0,    0,  3,  3,  3,   0,  0);
    idle();
    @(posedge CLK);
    #3;
    RSTn = 0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge CLK);
    RSTn = 1;
    step(1, 11, 9,    0, 0,    0,  1,  11, 9,   0,  0);
    idle();

    repeat (4) @(posedge CLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
